// File: rtl/slc3_pkg.sv
// Shared definitions for the CPU datapath slice.
// Contents:
//   WORD_W      - width of the CPU data bus and bus-loaded registers
//   mem_state_t - states of the SRAM access sequencer
package slc3_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

endpackage

// File: rtl/reg_ld.sv
// Loadable register with synchronous active-high clear.
// Ports:
//   Clk   - clock, updates on rising edge
//   Reset - synchronous clear to all-zero
//   ld    - load enable
//   d     - data to load
//   q     - registered value
module reg_ld #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear on reset, otherwise load when enabled and hold when not.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            q <= {W{1'b0}};
        end else if (ld) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/bus_load_mem_ctrl.sv
// Bus-loaded MAR/MDR/IR plus the SRAM access sequencer.
// Ports:
//   Clk, Reset          - clock and synchronous active-high reset
//   bus                 - shared 16-bit data bus
//   LD_MAR/LD_MDR/LD_IR - load strobes from the control unit
//   mem_start, mem_we   - start an access; direction sampled with start
//   mem_rdata           - SRAM read data
//   MAR, MDR, IR        - register contents
//   mem_addr, mem_wdata - SRAM address/write data (MAR, MDR)
//   mem_ce_n/oe_n/we_n  - active-low SRAM strobes
//   busy, mem_done      - access in progress / one-cycle completion pulse
module bus_load_mem_ctrl
    import slc3_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [WORD_W-1:0] bus,
    input  logic              LD_MAR,
    input  logic              LD_MDR,
    input  logic              LD_IR,
    input  logic              mem_start,
    input  logic              mem_we,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [WORD_W-1:0] MAR,
    output logic [WORD_W-1:0] MDR,
    output logic [WORD_W-1:0] IR,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_ce_n,
    output logic              mem_oe_n,
    output logic              mem_we_n,
    output logic              busy,
    output logic              mem_done
);

    localparam int               CNT_W    = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mem_state_t        state_r;
    mem_state_t        state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_s;
    logic              is_write_r;
    logic              is_write_s;

    logic              access_s;
    logic              last_s;
    logic              rd_done_s;
    logic              mar_ld_s;
    logic              mdr_ld_s;
    logic [WORD_W-1:0] mdr_d_s;

    assign access_s  = (state_r == ACCESS);
    assign last_s    = access_s && (cnt_r == CNT_LAST);
    // The edge that ends the last ACCESS cycle of a read captures SRAM data.
    assign rd_done_s = last_s && !is_write_r;

    // MAR/MDR are frozen while busy so address and write data stay stable.
    assign mar_ld_s  = LD_MAR && !busy;
    assign mdr_ld_s  = (LD_MDR && !busy) || rd_done_s;
    assign mdr_d_s   = rd_done_s ? mem_rdata : bus;

    reg_ld #(.W(WORD_W)) u_mar (
        .Clk   (Clk),
        .Reset (Reset),
        .ld    (mar_ld_s),
        .d     (bus),
        .q     (MAR)
    );

    reg_ld #(.W(WORD_W)) u_mdr (
        .Clk   (Clk),
        .Reset (Reset),
        .ld    (mdr_ld_s),
        .d     (mdr_d_s),
        .q     (MDR)
    );

    reg_ld #(.W(WORD_W)) u_ir (
        .Clk   (Clk),
        .Reset (Reset),
        .ld    (LD_IR),
        .d     (bus),
        .q     (IR)
    );

    // Next-state, wait counter and direction-latch logic.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        is_write_s = is_write_r;
        case (state_r)
            IDLE: begin
                if (mem_start) begin
                    state_s    = ACCESS;
                    cnt_s      = {CNT_W{1'b0}};
                    is_write_s = mem_we;
                end else begin
                    state_s    = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = DONE;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            is_write_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            is_write_r <= is_write_s;
        end
    end

    // Strobes and status decoded purely from registered state.
    assign mem_ce_n  = !access_s;
    assign mem_oe_n  = !(access_s && !is_write_r);
    assign mem_we_n  = !(access_s && is_write_r);
    assign busy      = (state_r != IDLE);
    assign mem_done  = (state_r == DONE);
    assign mem_addr  = MAR;
    assign mem_wdata = MDR;

endmodule

// File: tb/tb_bus_load_mem_ctrl.sv
// Self-checking bench for bus_load_mem_ctrl (WAIT_CYCLES = 2).
module tb_bus_load_mem_ctrl;

    localparam int W = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] bus;
    logic        LD_MAR, LD_MDR, LD_IR;
    logic        mem_start, mem_we;
    logic [15:0] mem_rdata;
    logic [15:0] MAR, MDR, IR, mem_addr, mem_wdata;
    logic        mem_ce_n, mem_oe_n, mem_we_n, busy, mem_done;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    // Model: registers plus "cycles since accepted start" (0 = idle,
    // 1..W = access cycles, W+1 = completion cycle).
    logic [15:0] m_mar = 16'h0, m_mdr = 16'h0, m_ir = 16'h0;
    int          m_age = 0;
    bit          m_wr  = 1'b0;

    bus_load_mem_ctrl #(.WAIT_CYCLES(W)) dut (
        .Clk(Clk), .Reset(Reset), .bus(bus),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR),
        .mem_start(mem_start), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .MAR(MAR), .MDR(MDR), .IR(IR), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
        .busy(busy), .mem_done(mem_done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update from the inputs seen at each rising edge.
    always @(posedge Clk) begin
        bit busy_m;
        busy_m = (m_age != 0);
        if (Reset) begin
            m_mar = 16'h0; m_mdr = 16'h0; m_ir = 16'h0; m_age = 0; m_wr = 1'b0;
        end else begin
            if (LD_IR) m_ir = bus;
            if (LD_MAR && !busy_m) m_mar = bus;
            if (LD_MDR && !busy_m) m_mdr = bus;
            else if (m_age == W && !m_wr) m_mdr = mem_rdata;
            if (m_age == 0) begin
                if (mem_start) begin m_age = 1; m_wr = mem_we; end
            end else if (m_age == W + 1) m_age = 0;
            else m_age = m_age + 1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge Clk) begin
        if (check_en) begin
            bit acc;
            acc = (m_age >= 1) && (m_age <= W);
            chk("mar",       MAR,       m_mar);
            chk("mdr",       MDR,       m_mdr);
            chk("ir",        IR,        m_ir);
            chk("mem_addr",  mem_addr,  m_mar);
            chk("mem_wdata", mem_wdata, m_mdr);
            chk("ce_n",      {15'h0, mem_ce_n}, {15'h0, !acc});
            chk("oe_n",      {15'h0, mem_oe_n}, {15'h0, !(acc && !m_wr)});
            chk("we_n",      {15'h0, mem_we_n}, {15'h0, !(acc && m_wr)});
            chk("busy",      {15'h0, busy},     {15'h0, m_age != 0});
            chk("done",      {15'h0, mem_done}, {15'h0, m_age == W + 1});
        end
    end

    task automatic step();
        @(negedge Clk);
        #1;
    endtask

    task automatic strobes(input string tag, input logic ce, input logic oe, input logic we);
        chk({tag, "_ce_n"}, {15'h0, mem_ce_n}, {15'h0, ce});
        chk({tag, "_oe_n"}, {15'h0, mem_oe_n}, {15'h0, oe});
        chk({tag, "_we_n"}, {15'h0, mem_we_n}, {15'h0, we});
    endtask

    initial begin
        Reset = 1'b1; bus = 16'h0; LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0;
        mem_start = 1'b0; mem_we = 1'b0; mem_rdata = 16'h0;
        step();
        check_en = 1'b1;
        step();
        // Reset state
        chk("rst_mar", MAR, 16'h0000);
        chk("rst_mdr", MDR, 16'h0000);
        chk("rst_ir",  IR,  16'h0000);
        strobes("rst", 1'b1, 1'b1, 1'b1);
        chk("rst_busy", {15'h0, busy}, 16'h0000);
        chk("rst_done", {15'h0, mem_done}, 16'h0000);
        Reset = 1'b0;
        bus = 16'h3000; LD_MAR = 1'b1;
        step();
        chk("ld_mar", MAR, 16'h3000);

        // Read access
        bus = 16'h0010;
        step();
        LD_MAR = 1'b0; mem_rdata = 16'hBEEF; mem_start = 1'b1; mem_we = 1'b0;
        step();                                    // T+1
        strobes("rd1", 1'b0, 1'b0, 1'b1);
        mem_start = 1'b0;
        step();                                    // T+2
        strobes("rd2", 1'b0, 1'b0, 1'b1);
        step();                                    // T+3
        chk("rd_done", {15'h0, mem_done}, 16'h0001);
        chk("rd_mdr", MDR, 16'hBEEF);
        step();                                    // T+4
        chk("rd_busy_end", {15'h0, busy}, 16'h0000);

        // Write access
        bus = 16'h1234; LD_MDR = 1'b1; mem_we = 1'b1;
        step();
        LD_MDR = 1'b0; mem_start = 1'b1; mem_rdata = 16'hDEAD;
        step();
        strobes("wr1", 1'b0, 1'b1, 1'b0);
        chk("wr1_wdata", mem_wdata, 16'h1234);
        mem_start = 1'b0;
        step();
        strobes("wr2", 1'b0, 1'b1, 1'b0);
        step();
        chk("wr_done", {15'h0, mem_done}, 16'h0001);
        chk("wr_mdr", MDR, 16'h1234);
        step();

        // Load lockout during an access
        mem_start = 1'b1; mem_we = 1'b0; mem_rdata = 16'hA5A5;
        step();                                    // T+1
        LD_MAR = 1'b1; bus = 16'hFFFF;
        step();                                    // T+2
        chk("lock_mar", MAR, 16'h0010);
        LD_MAR = 1'b0; LD_IR = 1'b1; bus = 16'h5020;
        step();                                    // T+3 completion
        chk("lock_ir", IR, 16'h5020);
        chk("lock_mdr", MDR, 16'hA5A5);
        LD_IR = 1'b0;                              // start still high here
        step();                                    // T+4
        chk("lock_no_queue", {15'h0, busy}, 16'h0000);
        mem_start = 1'b0;
        step();
        chk("lock_single_done", {15'h0, mem_done}, 16'h0000);

        // Same-cycle load and start
        bus = 16'h0042; LD_MAR = 1'b1; mem_start = 1'b1; mem_rdata = 16'h0BAD;
        step();
        chk("same_addr1", mem_addr, 16'h0042);
        LD_MAR = 1'b0; mem_start = 1'b0; bus = 16'hFFFF;
        step();
        chk("same_addr2", mem_addr, 16'h0042);
        step();
        chk("same_addr3", mem_addr, 16'h0042);
        chk("same_mdr", MDR, 16'h0BAD);
        step();

        // Reset mid-access
        mem_start = 1'b1; mem_we = 1'b0;
        step();
        Reset = 1'b1; mem_start = 1'b0;
        step();
        strobes("mid_rst", 1'b1, 1'b1, 1'b1);
        chk("mid_rst_mdr", MDR, 16'h0000);
        chk("mid_rst_busy", {15'h0, busy}, 16'h0000);
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_rst_nodone", {15'h0, mem_done}, 16'h0000);
        end

        // Back-to-back writes with start held high
        bus = 16'h7777; LD_MDR = 1'b1;
        step();
        LD_MDR = 1'b0; mem_start = 1'b1; mem_we = 1'b1;
        for (int i = 0; i < 12; i++) step();
        mem_start = 1'b0;
        step();
        step();
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bus_load_mem_ctrl.md
# bus_load_mem_ctrl

Receiving end of the 16-bit CPU data bus. It holds the bus-loaded registers MAR, MDR and IR, and runs the memory-access state machine that moves data between MDR and the external SRAM. It sits beside the bus driver mux. It captures whatever value is on `bus` when the control unit raises a load strobe. It sequences SRAM read/write cycles with a fixed wait-state count and reports completion back to the control FSM.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: SRAM access length in cycles; legal range is ≥1.

Ports:
- `Clk` in 1: single clock; all state updates on the rising edge.
- `Reset` in 1: synchronous, active-high.
- `bus` in 16: shared data bus.
- `LD_MAR` in 1: load MAR from `bus`.
- `LD_MDR` in 1: load MDR from `bus`.
- `LD_IR` in 1: load IR from `bus`.
- `mem_start` in 1: start an SRAM access using the current address.
- `mem_we` in 1: sampled with `mem_start`; 1 = write MDR to memory, 0 = read into MDR.
- `mem_rdata` in 16: SRAM read data.
- `MAR` out 16: memory address register.
- `MDR` out 16: memory data register.
- `IR` out 16: instruction register.
- `mem_addr` out 16: equals MAR.
- `mem_wdata` out 16: equals MDR.
- `mem_ce_n` out 1: SRAM chip enable, active-low.
- `mem_oe_n` out 1: SRAM output enable, active-low.
- `mem_we_n` out 1: SRAM write enable, active-low.
- `busy` out 1: an access is in progress.
- `mem_done` out 1: one-cycle completion pulse.

## Operation
- States:
  - IDLE: strobes inactive.
  - ACCESS: SRAM cycle in progress; counter runs 0..WAIT_CYCLES-1.
  - DONE: one cycle; `mem_done`=1.
- Transitions:
  - IDLE→ACCESS on `mem_start`. The access direction is latched from `mem_we` into an internal `is_write` bit.
  - ACCESS→DONE when the counter reaches WAIT_CYCLES-1.
  - DONE→IDLE unconditionally.
- Strobes:
  - During ACCESS: `mem_ce_n`=0. `mem_oe_n`=0 for a read, `mem_we_n`=0 for a write.
  - In IDLE and DONE: all three strobes are 1.
- Read completion: MDR ← `mem_rdata`, sampled at the rising edge that ends the last ACCESS cycle. A write does not modify MDR.
- Bus loads:
  - In IDLE, `LD_IR` loads independently of the other strobes.
  - `LD_MAR` and `LD_MDR` are ignored while `busy`=1, so address and write data stay stable for the whole access.
  - `LD_IR` is honoured in any state.
- Same-cycle `mem_start` + `LD_MAR` (or `LD_MDR`) in IDLE: the register loads the bus value at that edge, and the access uses the new value.
- `mem_start` while `busy`=1 is ignored; it is not queued.
- Width: all data paths are 16 bits with no truncation or extension. The counter is $clog2(WAIT_CYCLES+1) bits.

## Timing
- Reset values:
  - MAR, MDR, IR = 16'h0000.
  - State IDLE, counter 0.
  - `mem_ce_n`, `mem_oe_n`, `mem_we_n` = 1.
  - `busy`, `mem_done` = 0.
- Register loads: the value on `bus` in cycle T is visible on the output from cycle T+1.
- Access latency: `mem_start` in cycle T gives:
  - ACCESS in cycles T+1 .. T+WAIT_CYCLES.
  - DONE in cycle T+WAIT_CYCLES+1: `mem_done`=1, and the new MDR is visible for a read.
  - IDLE again from T+WAIT_CYCLES+2.
- `busy` is 1 during ACCESS and DONE.
- Back-to-back accesses: the earliest next `mem_start` is accepted in cycle T+WAIT_CYCLES+2. The `mem_start` sampled during DONE is ignored.
- Reset mid-access: next cycle is IDLE, all strobes are 1, MDR is cleared to 0, and no `mem_done` pulse occurs.
- Outputs are registered or decoded from state only. There is no combinational path from `bus` or `mem_rdata` to any output.

## Structure
- Shared package `slc3_pkg` holds:
  - `WORD_W` = 16.
  - typedef `mem_state_t` {IDLE, ACCESS, DONE}.
- Sub-module `reg_ld` (parameterised width, synchronous reset, load enable) is instantiated three times for MAR, MDR and IR. MDR's load enable and data input come from a small mux: the bus load or the read completion.
- The FSM and wait counter live in the top level.

## Test plan
- Reset check: after `Reset`, all registers are 0, all strobes are 1, and `busy` = `mem_done` = 0. Then `bus`=16'h3000 with `LD_MAR`=1 → MAR = 16'h3000 next cycle.
- Read, WAIT_CYCLES=2: MAR=16'h0010, `mem_rdata`=16'hBEEF, `mem_start`=1, `mem_we`=0 at T → `mem_oe_n`=0 in T+1..T+2; at T+3 `mem_done`=1 and MDR=16'hBEEF; `busy` is 0 at T+4.
- Write: MDR=16'h1234, `mem_we`=1 → `mem_we_n`=0 for 2 cycles, `mem_oe_n` stays 1, MDR stays 16'h1234, and `mem_wdata`=16'h1234 throughout.
- Load lockout: during ACCESS, pulse `LD_MAR` with `bus`=16'hFFFF and `mem_start` → MAR is unchanged, no second access starts, and a single `mem_done` pulse occurs. `LD_IR` with `bus`=16'h5020 in the same window → IR = 16'h5020.
- Same-cycle load and start: `LD_MAR` with `bus`=16'h0042 plus `mem_start` in IDLE → `mem_addr` = 16'h0042 for the whole access.
- Reset mid-access: assert `Reset` in the first ACCESS cycle → next cycle is IDLE, all strobes are 1, MDR = 0, and `mem_done` is never asserted.
